// File: rtl/tmr_ctrl_pkg.sv
// Shared encodings for the timer control stage: FSM states and mode values.
package tmr_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2
    } tmr_state_e;

    localparam logic ModeOneshot  = 1'b0;
    localparam logic ModePeriodic = 1'b1;

endpackage

// File: rtl/tmr_presc.sv
// Reloadable down-counter prescaler; tick fires while running and the count is zero.
module tmr_presc
    import tmr_ctrl_pkg::*;
#(
    parameter int unsigned P = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         run_i,
    input  logic [P-1:0] value_i,
    output logic         tick_o
);

    logic [P-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? value_i : cnt_q - P'(1);
        end
    end

    assign tick_o = run_i && (cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tmr_ctrl.sv
// Timer control: drives load/enable of an external up-counter and turns its
// terminal count into a sticky interrupt with overrun detection.
module tmr_ctrl
    import tmr_ctrl_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned P = 4
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         START,
    input  logic         STOP,
    input  logic         MODE,
    input  logic [N-1:0] RELOAD,
    input  logic [P-1:0] PRESC,
    input  logic         COUT,
    input  logic         IRQ_ACK,
    output logic         CNT_EN,
    output logic         CNT_PL,
    output logic [N-1:0] CNT_D,
    output logic         IRQ,
    output logic         OVR,
    output logic         BUSY
);

    tmr_state_e   state_q, state_d;
    logic [N-1:0] load_val_q, load_val_d;
    logic [P-1:0] presc_q, presc_d;
    logic         mode_q, mode_d;
    logic         irq_q, irq_d;
    logic         ovr_q, ovr_d;
    logic         presc_load, presc_run;
    logic         tick, term, term_evt;

    assign presc_load = (state_q == StLoad);
    assign presc_run  = (state_q == StRun);

    tmr_presc #(.P(P)) u_presc (
        .clk_i  (CLK),
        .rst_ni (RESETN),
        .load_i (presc_load),
        .run_i  (presc_run),
        .value_i(presc_q),
        .tick_o (tick)
    );

    assign term     = tick & COUT;
    // A same-cycle STOP suppresses both the interrupt and the periodic reload.
    assign term_evt = term & ~STOP;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: state_d = StIdle;
            StLoad: state_d = StRun;
            StRun:  if (term && mode_q == ModeOneshot) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (START) state_d = StLoad;
        if (STOP)  state_d = StIdle;
    end

    always_comb begin
        CNT_PL = 1'b0;
        CNT_EN = 1'b0;
        if (RESETN) begin
            case (state_q)
                StLoad: CNT_PL = 1'b1;
                StRun: begin
                    if (term) CNT_PL = (mode_q == ModePeriodic) && !STOP;
                    else      CNT_EN = tick;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        load_val_d = load_val_q;
        presc_d    = presc_q;
        mode_d     = mode_q;
        if (START && !STOP) begin
            load_val_d = N'(0) - RELOAD;
            presc_d    = PRESC;
            mode_d     = MODE;
        end
        irq_d = irq_q;
        ovr_d = ovr_q;
        if (IRQ_ACK) begin
            irq_d = 1'b0;
            ovr_d = 1'b0;
        end
        if (term_evt) begin
            irq_d = 1'b1;
            if (irq_q && !IRQ_ACK) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            load_val_q <= '0;
            presc_q    <= '0;
            mode_q     <= ModeOneshot;
            irq_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            load_val_q <= load_val_d;
            presc_q    <= presc_d;
            mode_q     <= mode_d;
            irq_q      <= irq_d;
            ovr_q      <= ovr_d;
        end
    end

    assign CNT_D = load_val_q;
    assign IRQ   = irq_q;
    assign OVR   = ovr_q;
    assign BUSY  = (state_q != StIdle);

endmodule

// File: doc/tmr_ctrl.md
Name: tmr_ctrl

Overview:
- Timer control stage that drives an N-bit loadable up-counter (EN/PL/D inputs, all-ones terminal output COUT) and consumes its terminal count.
- Sits directly upstream and downstream of the counter cell in the datapath: it generates load value, load strobe and count enable, and turns terminal counts into an interrupt.
- Supports one-shot and periodic modes, a programmable prescaler, and a sticky IRQ with acknowledge and overrun flag.

Parameters:
- N, 8, counter width; must match the attached counter.
- P, 4, prescaler width.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESETN  input  1  reset, synchronous, active-low.
- START  input  1  one-cycle pulse; samples RELOAD, PRESC and MODE, then (re)starts the timer.
- STOP  input  1  one-cycle pulse; halts the timer.
- MODE  input  1  0 = one-shot, 1 = periodic; sampled on START.
- RELOAD  input  N  period in ticks; 0 means 2^N.
- PRESC  input  P  one tick every PRESC+1 CLK cycles.
- COUT  input  1  from counter; 1 when counter Q is all ones (ungated).
- IRQ_ACK  input  1  clears IRQ and OVR.
- CNT_EN  output  1  counter increment enable.
- CNT_PL  output  1  counter parallel load, active-high; the counter gives it priority over EN.
- CNT_D  output  N  counter load value.
- IRQ  output  1  sticky terminal-count interrupt.
- OVR  output  1  terminal event occurred while IRQ was still pending.
- BUSY  output  1  1 in LOAD or RUN.

Behaviour:
- Reset (RESETN=0 at an edge): state IDLE; IRQ=OVR=0; CNT_D=0; prescaler=0; stored MODE=0. CNT_EN and CNT_PL are forced 0 while RESETN=0. Reset mid-run aborts with no IRQ.
- States:
  - IDLE: CNT_EN=0, CNT_PL=0, BUSY=0.
  - LOAD: exactly one cycle. CNT_PL=1, CNT_EN=0. Prescaler counter loads stored PRESC. Next state is RUN.
  - RUN: BUSY=1; behaviour defined by the tick and terminal rules below.
- START (any state): at the edge, CNT_D <= (2^N - RELOAD) mod 2^N, i.e. two's complement of RELOAD (RELOAD=0 gives CNT_D=0). PRESC and MODE are stored at the same edge. Next state is LOAD.
- STOP (any state): next state IDLE. STOP beats START in the same cycle, and STOP beats a terminal event in the same cycle (no IRQ, no reload).
- Tick: tick = RUN and prescaler==0.
  - On tick, prescaler <= stored PRESC; otherwise, in RUN, prescaler decrements.
  - PRESC=0 gives a tick every cycle.
- Terminal event: term = tick and COUT (combinational).
- CNT_EN = tick and not term. CNT_EN and CNT_PL are never both 1.
- On term:
  - Periodic: CNT_PL=1 in the same cycle, counter reloads CNT_D, stay in RUN.
  - One-shot: CNT_PL=0, CNT_EN=0, next state IDLE; counter holds all ones.
- Period: with RELOAD=R, the first term occurs R ticks after the LOAD cycle, then every R ticks.
- IRQ set/clear: set at the edge after term. IRQ_ACK clears IRQ and OVR. If term and IRQ_ACK coincide, IRQ stays 1 and OVR clears.
- OVR: set at the edge after term when IRQ=1 and IRQ_ACK=0.
- Timing: CNT_PL and CNT_EN are combinational from state, prescaler and COUT. All other outputs are registered.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/LOAD/RUN (2-bit);
  - mode constants MODE_ONESHOT=0 and MODE_PERIODIC=1.
- One sub-module, tmr_presc: P-bit reloadable down-counter with inputs load, run, value and output tick.
- The FSM, IRQ/OVR logic and CNT_D register stay in tmr_ctrl.

Test Plan:
Bench attaches a behavioural N=8 loadable up-counter with COUT = &Q.
1. Periodic, MODE=1, RELOAD=5, PRESC=0, START at cycle 0 -> CNT_PL=1 and CNT_D=8'hFB in cycle 1; Q=FB..FF over cycles 2-6; term in cycle 6 with CNT_PL=1; IRQ=1 from cycle 7; next term in cycle 11.
2. One-shot, MODE=0, RELOAD=3, PRESC=2 -> CNT_EN pulses every 3rd cycle; after 3 ticks IRQ=1, state IDLE, BUSY=0, Q stays 8'hFF with CNT_EN=0 thereafter.
3. IRQ left pending across a second term in periodic, RELOAD=2 -> OVR=1. IRQ_ACK coincident with the third term -> IRQ stays 1, OVR=0.
4. STOP and term in the same cycle -> no IRQ, no CNT_PL, BUSY=0 next cycle. START and STOP together from IDLE -> stays IDLE.
5. RELOAD=0, PRESC=0 -> CNT_D=8'h00; first term after 256 ticks.
6. RESETN=0 for one cycle during RUN with IRQ=1 -> next cycle IRQ=OVR=BUSY=0, CNT_D=0, CNT_EN=CNT_PL=0 during the reset cycle. START during RUN -> LOAD, with new RELOAD sampled.
